// File: rtl/mesh_switch_allocator_pkg.sv
// ============================================================================
// Module      : mesh_pkg
// Description : Shared constants and types for the MESH router switch
//               allocator (port count, port indices, vector/index types).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mesh_pkg;

  localparam int N_PORTS = 5;
  localparam int IDX_W   = $clog2(N_PORTS);

  // Router port indices in [c,n,e,s,w] order; index 0 is the local core
  localparam int PORT_C = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  typedef logic [0:N_PORTS-1] port_vec_t;
  typedef logic [IDX_W-1:0]   port_idx_t;

  // Successor of a port index with wrap back to 0 after the last port
  function automatic port_idx_t next_idx(port_idx_t idx);
    return (idx == port_idx_t'(N_PORTS - 1)) ? '0 : idx + port_idx_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mesh_switch_allocator_if.sv
// ============================================================================
// Module      : mesh_switch_allocator_if
// Description : Request/grant/crossbar-select bundle between the route
//               calculator, input buffers, crossbar and the switch allocator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mesh_switch_allocator_if
  import mesh_pkg::*;
  ;

  port_vec_t [0:N_PORTS-1] i_output_req;   // [input][output], one-hot per input
  port_vec_t               i_output_en;    // per output: downstream credit
  port_vec_t [0:N_PORTS-1] o_input_grant;  // [output][input], one-hot per output
  port_vec_t               o_output_grant; // per input: buffer pop
  port_idx_t [0:N_PORTS-1] o_xbar_sel;     // per output: registered select
  port_vec_t               o_xbar_val;     // per output: registered valid

  // Requester side (route calculator / buffers / crossbar)
  modport master (
    output i_output_req, i_output_en,
    input  o_input_grant, o_output_grant, o_xbar_sel, o_xbar_val
  );

  // Allocator side
  modport slave (
    input  i_output_req, i_output_en,
    output o_input_grant, o_output_grant, o_xbar_sel, o_xbar_val
  );

endinterface

`default_nettype wire

// File: rtl/mesh_switch_allocator_rr_arbiter.sv
// ============================================================================
// Module      : mesh_rr_arbiter
// Description : Single-output round-robin arbiter. Combinational one-hot grant
//               scanning from the priority pointer; pointer moves past the
//               winner on every grant and holds otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_rr_arbiter
  import mesh_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  port_vec_t req_i,   // requesting inputs
  input  logic      en_i,    // output can accept a packet this cycle
  output port_vec_t gnt_o,   // one-hot winner, zero when idle/blocked
  output port_idx_t win_o,   // binary index of the winner
  output logic      val_o    // a grant was made
);

  port_idx_t ptr_q;
  port_idx_t ptr_d;

  // Scan requests starting at the pointer, wrapping, and take the first hit
  always_comb begin
    int   w_idx;
    logic w_found;
    gnt_o   = '0;
    win_o   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    if (en_i) begin
      for (int k = 0; k < N_PORTS; k++) begin
        w_idx = int'(ptr_q) + k;
        if (w_idx >= N_PORTS) begin
          w_idx = w_idx - N_PORTS;
        end
        if (!w_found && req_i[w_idx]) begin
          w_found      = 1'b1;
          win_o        = port_idx_t'(w_idx);
          gnt_o[w_idx] = 1'b1;
        end
      end
    end
    val_o = w_found;
    ptr_d = w_found ? next_idx(win_o) : ptr_q;
  end

  // Priority pointer: lowest priority goes to the input just served
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mesh_switch_allocator.sv
// ============================================================================
// Module      : mesh_switch_allocator
// Description : Per-router output-port allocator. Transposes the one-hot
//               route requests, arbitrates each output with an independent
//               round-robin arbiter, returns pop grants to the input buffers
//               and registers the crossbar select/valid one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_switch_allocator
  import mesh_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  mesh_switch_allocator_if.slave        bus
);

  port_vec_t [0:N_PORTS-1] w_req_t;   // [output][input] requests
  port_vec_t [0:N_PORTS-1] w_gnt;     // [output][input] one-hot grants
  port_idx_t [0:N_PORTS-1] w_win;     // per output winner index
  port_vec_t               w_val;     // per output grant made
  port_vec_t               w_out_gnt; // per input granted

  port_vec_t               xbar_val_q;
  port_idx_t [0:N_PORTS-1] xbar_sel_q;

  generate
    for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
      for (genvar i = 0; i < N_PORTS; i++) begin : g_tr
        assign w_req_t[o][i] = bus.i_output_req[i][o];
      end

      mesh_rr_arbiter u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (w_req_t[o]),
        .en_i    (bus.i_output_en[o]),
        .gnt_o   (w_gnt[o]),
        .win_o   (w_win[o]),
        .val_o   (w_val[o])
      );
    end
  endgenerate

  // An input is popped when any output picked it (at most one can)
  always_comb begin
    w_out_gnt = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      w_out_gnt = w_out_gnt | w_gnt[o];
    end
  end

  // Crossbar stage: valid follows the grant, select holds when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xbar_val_q <= '0;
      xbar_sel_q <= '0;
    end else begin
      xbar_val_q <= w_val;
      for (int o = 0; o < N_PORTS; o++) begin
        if (w_val[o]) begin
          xbar_sel_q[o] <= w_win[o];
        end
      end
    end
  end

  assign bus.o_input_grant  = w_gnt;
  assign bus.o_output_grant = w_out_gnt;
  assign bus.o_xbar_val     = xbar_val_q;
  assign bus.o_xbar_sel     = xbar_sel_q;

  // Each input carries at most one output request at a time
  generate
    for (genvar i = 0; i < N_PORTS; i++) begin : g_chk
      a_req_onehot : assert property (
        @(posedge clk) disable iff (!reset_n) $onehot0(bus.i_output_req[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mesh_switch_allocator.sv
// ============================================================================
// Module      : tb_mesh_switch_allocator
// Description : Scoreboard bench for the switch allocator. A driver issues
//               directed and random request patterns, a reference model
//               predicts grants and crossbar state, and a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesh_switch_allocator;
  import mesh_pkg::*;

  typedef struct {
    port_vec_t [0:N_PORTS-1] igrant;
    port_vec_t               ogrant;
    port_vec_t               xval;
    port_idx_t [0:N_PORTS-1] xsel;
  } exp_t;

  logic clk;
  logic reset_n;

  mesh_switch_allocator_if u_if ();

  mesh_switch_allocator dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int                      m_ptr [N_PORTS];
  port_vec_t               m_xval;
  port_idx_t [0:N_PORTS-1] m_xsel;
  int                      pend  [N_PORTS];  // destination per input, -1 none
  port_vec_t               en_v;

  exp_t exp_q [$];
  int   n_checks;
  int   n_errors;

  task automatic model_clear();
    for (int o = 0; o < N_PORTS; o++) m_ptr[o] = 0;
    m_xval = '0;
    m_xsel = '0;
  endtask

  // Hold reset for n cycles with no requests
  task automatic reset_cycles(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      reset_n = 1'b0;
      u_if.i_output_req = '0;
      model_clear();
      e.igrant = '0; e.ogrant = '0; e.xval = '0; e.xsel = '0;
      exp_q.push_back(e);
    end
  endtask

  // One cycle: present pending requests, predict response, advance the model
  task automatic step();
    exp_t                    e;
    port_vec_t [0:N_PORTS-1] req;
    int                      win [N_PORTS];
    int                      i;
    @(posedge clk); #1;
    reset_n = 1'b1;
    req = '0;
    for (int k = 0; k < N_PORTS; k++) if (pend[k] >= 0) req[k][pend[k]] = 1'b1;
    u_if.i_output_req = req;
    u_if.i_output_en  = en_v;
    e.xval = m_xval; e.xsel = m_xsel; e.igrant = '0; e.ogrant = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      win[o] = -1;
      if (en_v[o]) begin
        for (int k = 0; k < N_PORTS; k++) begin
          i = (m_ptr[o] + k) % N_PORTS;
          if (win[o] < 0 && pend[i] == o) win[o] = i;
        end
      end
      if (win[o] >= 0) begin
        e.igrant[o][win[o]] = 1'b1;
        e.ogrant[win[o]]    = 1'b1;
      end
    end
    for (int o = 0; o < N_PORTS; o++) begin
      if (win[o] >= 0) begin
        m_ptr[o]     = (win[o] + 1) % N_PORTS;
        m_xval[o]    = 1'b1;
        m_xsel[o]    = port_idx_t'(win[o]);
        pend[win[o]] = -1;
      end else begin
        m_xval[o] = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drain();
    bit busy;
    for (int c = 0; c < 20; c++) begin
      busy = 1'b0;
      for (int k = 0; k < N_PORTS; k++) if (pend[k] >= 0) busy = 1'b1;
      if (busy) step();
    end
  endtask

  // Monitor: compare each expected entry against the DUT mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (u_if.o_input_grant !== e.igrant) begin
          n_errors++;
          $display("FAIL igrant t=%0t got=%b exp=%b", $time, u_if.o_input_grant, e.igrant);
        end
        n_checks++;
        if (u_if.o_output_grant !== e.ogrant) begin
          n_errors++;
          $display("FAIL ogrant t=%0t got=%b exp=%b", $time, u_if.o_output_grant, e.ogrant);
        end
        n_checks++;
        if (u_if.o_xbar_val !== e.xval) begin
          n_errors++;
          $display("FAIL xval t=%0t got=%b exp=%b", $time, u_if.o_xbar_val, e.xval);
        end
        n_checks++;
        if (u_if.o_xbar_sel !== e.xsel) begin
          n_errors++;
          $display("FAIL xsel t=%0t got=%h exp=%h", $time, u_if.o_xbar_sel, e.xsel);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    u_if.i_output_req = '0;
    u_if.i_output_en  = '1;
    en_v = '1;
    for (int k = 0; k < N_PORTS; k++) pend[k] = -1;
    model_clear();
    reset_cycles(2);

    // Single request e -> w, then observe crossbar stage
    pend[PORT_E] = PORT_W;
    step();
    step();

    // Inputs 0,1,3 continuously contend for output 2
    for (int c = 0; c < 6; c++) begin
      if (pend[0] < 0) pend[0] = 2;
      if (pend[1] < 0) pend[1] = 2;
      if (pend[3] < 0) pend[3] = 2;
      step();
    end
    drain();
    step();

    // Output 3 blocked for 4 cycles, then released
    pend[1] = 3;
    en_v[3] = 1'b0;
    repeat (4) step();
    en_v = '1;
    step();
    step();

    // Full permutation: every input granted in one cycle
    pend[0] = 1; pend[1] = 2; pend[2] = 3; pend[3] = 4; pend[4] = 0;
    step();
    step();

    // Input 4 wins output 0 again, then reset lands mid-stream
    pend[4] = 0;
    step();
    reset_cycles(2);
    pend[2] = 0; pend[4] = 0;
    step();
    drain();

    // Contention separated by idle cycles
    for (int r = 0; r < 3; r++) begin
      pend[0] = 2; pend[1] = 2; pend[3] = 2;
      step();
      repeat (3) step();
      drain();
    end

    // Randomized traffic with random credit and idle gaps
    for (int c = 0; c < 400; c++) begin
      for (int o = 0; o < N_PORTS; o++) en_v[o] = ($urandom_range(0, 3) != 0);
      if ((c % 25) >= 22) begin
        step();
      end else begin
        for (int k = 0; k < N_PORTS; k++) begin
          if (pend[k] < 0 && $urandom_range(0, 9) < 4) pend[k] = $urandom_range(0, N_PORTS - 1);
        end
        step();
      end
    end
    en_v = '1;
    drain();
    step();

    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain got=%0d exp=0 pending entries", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
